quadrant_reducer: RTL and testbench
===================================

# quadrant_reducer

- Parametrised, handshaked range-reduction stage for the trigonometric pipeline.
- Takes a fixed-point angle x and computes k = floor(x / HALF_PI) by iterative restoring division against a constant, one quotient bit per clock.
- Returns quadrant = k mod 4, the full quotient, and the reduced angle r = x − k·HALF_PI in [0, HALF_PI).
- Sits between operand conversion and the CORDIC/polynomial core; generalises the earlier fixed-width, enable-driven divider with configurable width, quotient depth, valid/ready flow control and optional signed input.

## Interface
- DATA_WIDTH, 32, width of angle and remainder words.
- FRAC_BITS, 29, fractional bits of the angle format (Q(DATA_WIDTH−FRAC_BITS).FRAC_BITS).
- QBITS, 3, quotient bits produced = iterations per operation; must be ≥2 and satisfy HALF_PI·2^QBITS > max |x|.
- HALF_PI, 32'h3243F6A9, round(π/2·2^FRAC_BITS), DATA_WIDTH bits.
- clk  in  1  single clock, all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  data_in valid.
- in_ready  out  1  block can accept; high only in IDLE and not in reset.
- data_in  in  DATA_WIDTH  angle x.
- out_valid  out  1  result valid; held until accepted.
- out_ready  in  1  downstream accepts result.
- quadrant  out  2  k mod 4.
- quotient  out  QBITS  k (low QBITS bits, after sign fix when enabled).
- data_out  out  DATA_WIDTH  reduced angle r, same format as data_in.

## Operation
- States: IDLE, RUN, FIX (only with signed build), DONE.
- IDLE: in_valid && in_ready at an edge → latch rem = |x| (zero-extended to DATA_WIDTH+QBITS), clear quotient register, latch sign, cnt = QBITS−1, → RUN.
- RUN, per edge at iteration i = cnt: if rem ≥ (HALF_PI << i) then rem −= HALF_PI << i and quot[i] = 1, else quot[i] = 0.
  - Comparator/subtractor width DATA_WIDTH+QBITS; no truncation before the final result.
  - cnt == 0 → FIX (signed build) or DONE; else cnt−1.
- FIX (signed build only; negative input): if rem == 0 then k = (−k) mod 2^QBITS, r = 0; else k = (−k−1) mod 2^QBITS, r = HALF_PI − rem. Non-negative input passes unchanged. → DONE.
- DONE: out_valid = 1; quadrant, quotient, data_out are stable.
  - out_ready at an edge → IDLE.
  - No input is accepted in the same cycle; in_ready is 0 in DONE.
- Outputs are driven from registers, updated only on entry to DONE.
- Input held while in_ready = 0 is ignored.
- Reset, any state, including mid-RUN/FIX/DONE: → IDLE; out_valid, quadrant, quotient, data_out, internal rem/quot/cnt = 0. The in-flight operation is discarded.
- Reset and in_valid asserted together: reset wins, nothing latched.

## Timing
- Acceptance edge = E0.
- Unsigned build: out_valid high after edge E0+QBITS.
- Signed build: out_valid high after edge E0+QBITS+1.
- out_valid falls after the edge where out_valid && out_ready.
- in_ready rises in the same cycle (combinational from state).
- Minimum initiation interval: QBITS+2 cycles (QBITS+3 signed) with out_ready held high.
- in_ready = (state == IDLE) && !reset; it is the only combinational output.

## Configuration
- QUAD_REDUCER_SIGNED_EN defined:
  - data_in is two's complement; magnitude is reduced, then FIX applies floor semantics.
  - Quadrant wraps mod 4; r is always in [0, HALF_PI).
  - FIX state and sign register exist.
- Not defined:
  - data_in is unsigned; no FIX state, no negation logic; latency QBITS.

## Test plan
Defaults throughout (DATA_WIDTH=32, FRAC_BITS=29, QBITS=3).
- x=0x00000000 → after 3 edges: quadrant 0, quotient 0, data_out 0x00000000.
- x=0x3243F6A9 (exact π/2) → quadrant 1, quotient 1, data_out 0x00000000.
- x=0x96CBE400 (3·HALF_PI+5) → quadrant 3, quotient 3, data_out 0x00000005. Then x=0xFFFFFFFF (unsigned) → quadrant 1, quotient 5, data_out 0x04AC2EB2.
- Back-pressure: out_ready=0 for 10 cycles after out_valid → all outputs stable, in_ready=0, new in_valid ignored. Raise out_ready → out_valid drops next cycle, in_ready=1.
- reset pulsed one cycle mid-RUN (after E0+1) → all outputs 0 the next cycle, in_ready=1; a new x=0x3243F6A9 then completes normally with quadrant 1.
- QUAD_REDUCER_SIGNED_EN: x=0xFFFFFFFF (−1 LSB) → after 4 edges: quadrant 3, quotient 7, data_out 0x3243F6A8. x=0xCDBC0957 (−HALF_PI) → quadrant 3, quotient 7, data_out 0.

Source files
------------

// File: rtl/quadrant_reducer_if.sv
// Handshake bundle for quadrant_reducer: angle in on the valid/ready input side,
// quadrant/quotient/reduced angle out on the valid/ready output side.
interface quadrant_reducer_if #(
    parameter int DATA_WIDTH = 32,
    parameter int QBITS      = 3
);
    logic                  in_valid;
    logic                  in_ready;
    logic [DATA_WIDTH-1:0] data_in;
    logic                  out_valid;
    logic                  out_ready;
    logic [1:0]            quadrant;
    logic [QBITS-1:0]      quotient;
    logic [DATA_WIDTH-1:0] data_out;

    modport master (
        output in_valid, data_in, out_ready,
        input  in_ready, out_valid, quadrant, quotient, data_out
    );

    modport slave (
        input  in_valid, data_in, out_ready,
        output in_ready, out_valid, quadrant, quotient, data_out
    );
endinterface

// File: rtl/quadrant_reducer.sv
// Range reduction x -> k = floor(x / HALF_PI), r = x - k*HALF_PI by restoring division,
// one quotient bit per clock. Define QUAD_REDUCER_SIGNED_EN for two's complement input.
//
// state | meaning
// IDLE  | waiting for input, in_ready high
// RUN   | one restoring-division step per clock, cnt = quotient bit index
// FIX   | floor correction for negative input (signed build only)
// DONE  | result held on out_valid until out_ready
module quadrant_reducer #(
    parameter int                    DATA_WIDTH = 32,
    parameter int                    FRAC_BITS  = 29,
    parameter int                    QBITS      = 3,
    parameter logic [DATA_WIDTH-1:0] HALF_PI    = 32'h3243F6A9
) (
    input logic               clk,
    input logic               reset,
    quadrant_reducer_if.slave bus
);
    localparam int RW = DATA_WIDTH + QBITS;
    localparam int CW = (QBITS > 1) ? $clog2(QBITS) : 1;

    generate
        if (QBITS < 2 || FRAC_BITS >= DATA_WIDTH) begin : g_param_check
            $error("quadrant_reducer: QBITS must be >= 2 and FRAC_BITS < DATA_WIDTH");
        end
    endgenerate

`ifdef QUAD_REDUCER_SIGNED_EN
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_FIX = 2'd2, S_DONE = 2'd3} state_t;
`else
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_DONE = 2'd3} state_t;
`endif

    state_t                state_q, state_d;
    logic [RW-1:0]         rem_q;
    logic [QBITS-1:0]      quot_q;
    logic [CW-1:0]         cnt_q;
    logic [QBITS-1:0]      quot_out_q;
    logic [DATA_WIDTH-1:0] rem_out_q;

    logic [RW-1:0]         hp_ext, trial, rem_step;
    logic                  rem_ge;
    logic [QBITS-1:0]      quot_step;
    logic [DATA_WIDTH-1:0] mag_in;

    assign hp_ext    = RW'(HALF_PI);
    assign trial     = hp_ext << cnt_q;
    assign rem_ge    = rem_q >= trial;
    assign rem_step  = rem_ge ? (rem_q - trial) : rem_q;
    assign quot_step = quot_q | (QBITS'(rem_ge) << cnt_q);

`ifdef QUAD_REDUCER_SIGNED_EN
    logic                  neg_in, neg_q;
    logic [QBITS-1:0]      quot_fix;
    logic [DATA_WIDTH-1:0] rem_fix;

    assign neg_in = bus.data_in[DATA_WIDTH-1];
    assign mag_in = neg_in ? -bus.data_in : bus.data_in;

    // Magnitude was divided; convert truncation toward zero into floor.
    always_comb begin
        quot_fix = quot_q;
        rem_fix  = rem_q[DATA_WIDTH-1:0];
        if (neg_q) begin
            if (rem_q == '0) begin
                quot_fix = -quot_q;
                rem_fix  = '0;
            end else begin
                quot_fix = ~quot_q;
                rem_fix  = HALF_PI - rem_q[DATA_WIDTH-1:0];
            end
        end
    end
`else
    assign mag_in = bus.data_in;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (bus.in_valid) state_d = S_RUN;
`ifdef QUAD_REDUCER_SIGNED_EN
            S_RUN:  if (cnt_q == '0) state_d = S_FIX;
            S_FIX:  state_d = S_DONE;
`else
            S_RUN:  if (cnt_q == '0) state_d = S_DONE;
`endif
            S_DONE: if (bus.out_ready) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rem_q      <= '0;
            quot_q     <= '0;
            cnt_q      <= '0;
            quot_out_q <= '0;
            rem_out_q  <= '0;
`ifdef QUAD_REDUCER_SIGNED_EN
            neg_q      <= 1'b0;
`endif
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (bus.in_valid) begin
                        rem_q  <= RW'(mag_in);
                        quot_q <= '0;
                        cnt_q  <= CW'(QBITS - 1);
`ifdef QUAD_REDUCER_SIGNED_EN
                        neg_q  <= neg_in;
`endif
                    end
                end
                S_RUN: begin
                    rem_q  <= rem_step;
                    quot_q <= quot_step;
                    if (cnt_q != '0) begin
                        cnt_q <= cnt_q - CW'(1);
                    end
`ifndef QUAD_REDUCER_SIGNED_EN
                    else begin
                        quot_out_q <= quot_step;
                        rem_out_q  <= rem_step[DATA_WIDTH-1:0];
                    end
`endif
                end
`ifdef QUAD_REDUCER_SIGNED_EN
                S_FIX: begin
                    quot_out_q <= quot_fix;
                    rem_out_q  <= rem_fix;
                end
`endif
                default: ;
            endcase
        end
    end

    assign bus.in_ready  = (state_q == S_IDLE) && !reset;
    assign bus.out_valid = (state_q == S_DONE);
    assign bus.quadrant  = quot_out_q[1:0];
    assign bus.quotient  = quot_out_q;
    assign bus.data_out  = rem_out_q;
endmodule

// File: tb/tb_quadrant_reducer.sv
// Scoreboard bench for quadrant_reducer: stimulus pushes expected results from an
// arithmetic reference model, a monitor pops and compares on each output handshake.
`timescale 1ns/1ps
module tb_quadrant_reducer;
    localparam int          DW = 32;
    localparam int          QB = 3;
    localparam logic [31:0] HP = 32'h3243F6A9;
`ifdef QUAD_REDUCER_SIGNED_EN
    localparam int LAT = QB + 1;
`else
    localparam int LAT = QB;
`endif

    logic clk = 1'b0;
    logic reset;

    quadrant_reducer_if #(.DATA_WIDTH(DW), .QBITS(QB)) bus();

    quadrant_reducer #(
        .DATA_WIDTH(DW), .FRAC_BITS(29), .QBITS(QB), .HALF_PI(HP)
    ) dut (
        .clk(clk), .reset(reset), .bus(bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]    quad;
        logic [QB-1:0] quot;
        logic [DW-1:0] r;
        int            acc;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    bit   seen  = 1'b0;
    bit   rnd_bp = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Floor division of the angle by HALF_PI in plain 64-bit arithmetic.
    function automatic exp_t model(input logic [DW-1:0] x);
        exp_t   e;
        longint sx, hp, k, r;
`ifdef QUAD_REDUCER_SIGNED_EN
        sx = longint'($signed(x));
`else
        sx = longint'(x);
`endif
        hp = longint'(HP);
        k  = sx / hp;
        if (sx < 0 && (sx % hp) != 0) k = k - 1;
        r  = sx - k * hp;
        e.quad = k[1:0];
        e.quot = k[QB-1:0];
        e.r    = r[DW-1:0];
        e.acc  = 0;
        return e;
    endfunction

    function automatic exp_t mk(input logic [1:0] q, input logic [QB-1:0] k, input logic [DW-1:0] r);
        exp_t e;
        e.quad = q; e.quot = k; e.r = r; e.acc = 0;
        return e;
    endfunction

    initial forever begin
        exp_t e;
        @(negedge clk);
        if (!reset && bus.out_valid) begin
            if (!seen) begin
                seen = 1'b1;
                if (sb.size() == 0) check("unexpected_out_valid", bus.out_valid, 0);
                else check("latency", cyc - sb[0].acc, LAT);
            end
            if (bus.out_ready) begin
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    check("quadrant", bus.quadrant, e.quad);
                    check("quotient", bus.quotient, e.quot);
                    check("data_out", bus.data_out, e.r);
                end
                seen = 1'b0;
            end
        end
    end

    initial forever begin
        @(posedge clk);
        #2;
        if (rnd_bp) bus.out_ready = 1'($urandom_range(0, 1));
    end

    // Called at posedge+2; returns at posedge+2 after the acceptance edge.
    task automatic send(input logic [DW-1:0] x, input exp_t e);
        bit ok = 1'b0;
        bus.in_valid = 1'b1;
        bus.data_in  = x;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (bus.in_ready) begin
                e.acc = cyc + 1;
                sb.push_back(e);
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check("accept_timeout", bus.in_ready, 1);
        @(posedge clk);
        #2;
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_idle();
        bit ok = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(posedge clk);
            #2;
            if (sb.size() == 0 && !bus.out_valid) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check("drain_timeout", sb.size(), 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t e;
        bit   ok;
        logic [DW-1:0] x;
        logic [DW-1:0] edge_vals [6];

        reset = 1'b1;
        bus.in_valid  = 1'b0;
        bus.data_in   = '0;
        bus.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        bus.in_valid = 1'b1;
        bus.data_in  = HP;
        @(negedge clk);
        check("rst_in_ready", bus.in_ready, 0);
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_quotient", bus.quotient, 0);
        check("rst_data_out", bus.data_out, 0);
        @(posedge clk);
        #2;
        bus.in_valid = 1'b0;
        reset = 1'b0;
        @(negedge clk);
        check("post_rst_in_ready", bus.in_ready, 1);
        check("post_rst_no_accept", bus.out_valid, 0);
        @(posedge clk);
        #2;

        send(32'h0000_0000, mk(2'd0, 3'd0, 32'h0000_0000));
        wait_idle();
        send(HP, mk(2'd1, 3'd1, 32'h0000_0000));
        wait_idle();
`ifdef QUAD_REDUCER_SIGNED_EN
        send(32'hFFFF_FFFF, mk(2'd3, 3'd7, 32'h3243_F6A8));
        wait_idle();
        send(32'hCDBC_0957, mk(2'd3, 3'd7, 32'h0000_0000));
        wait_idle();
`else
        send(32'h96CB_E400, mk(2'd3, 3'd3, 32'h0000_0005));
        wait_idle();
        send(32'hFFFF_FFFF, mk(2'd1, 3'd5, 32'h04AC_2EB2));
        wait_idle();
`endif
        // Back-to-back with out_ready high.
        send(32'h1234_5678, model(32'h1234_5678));
        send(HP - 32'd1, model(HP - 32'd1));
        wait_idle();

        // Back-pressure: result must hold and new input must be ignored.
        bus.out_ready = 1'b0;
        e = model(32'h5A5A_1234);
        send(32'h5A5A_1234, e);
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (bus.out_valid) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check("bp_valid_timeout", bus.out_valid, 1);
        @(posedge clk);
        #2;
        bus.in_valid = 1'b1;
        bus.data_in  = 32'h0BAD_0BAD;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("bp_out_valid", bus.out_valid, 1);
            check("bp_in_ready", bus.in_ready, 0);
            check("bp_quadrant", bus.quadrant, e.quad);
            check("bp_quotient", bus.quotient, e.quot);
            check("bp_data_out", bus.data_out, e.r);
            @(posedge clk);
            #2;
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("bp_release_valid", bus.out_valid, 0);
        check("bp_release_in_ready", bus.in_ready, 1);
        repeat (4) @(negedge clk);
        check("bp_ignored_input", bus.out_valid, 0);
        check("bp_sb_empty", sb.size(), 0);
        @(posedge clk);
        #2;

        // Reset one cycle mid-RUN discards the operation.
        send(32'h1ABC_DEF0, model(32'h1ABC_DEF0));
        @(posedge clk);
        #2;
        reset = 1'b1;
        @(posedge clk);
        #2;
        reset = 1'b0;
        sb.delete();
        seen = 1'b0;
        @(negedge clk);
        check("midrun_rst_out_valid", bus.out_valid, 0);
        check("midrun_rst_quadrant", bus.quadrant, 0);
        check("midrun_rst_quotient", bus.quotient, 0);
        check("midrun_rst_data_out", bus.data_out, 0);
        check("midrun_rst_in_ready", bus.in_ready, 1);
        @(posedge clk);
        #2;
        send(HP, mk(2'd1, 3'd1, 32'h0000_0000));
        wait_idle();

        // Boundary values through the reference model.
        edge_vals[0] = 32'h8000_0000;
        edge_vals[1] = 32'h7FFF_FFFF;
        edge_vals[2] = HP + HP;
        edge_vals[3] = HP + HP - 32'd1;
        edge_vals[4] = 32'h0000_0001;
        edge_vals[5] = 32'hFFFF_FFFE;
        for (int i = 0; i < 6; i++) begin
            send(edge_vals[i], model(edge_vals[i]));
        end
        wait_idle();

        // Random angles with random gaps and random back-pressure.
        rnd_bp = 1'b1;
        for (int n = 0; n < 40; n++) begin
            repeat ($urandom_range(0, 3)) begin
                @(posedge clk);
                #2;
            end
            x = $urandom;
            send(x, model(x));
        end
        wait_idle();
        rnd_bp = 1'b0;
        @(posedge clk);
        #2;
        bus.out_ready = 1'b1;
        wait_idle();
        check("final_sb_empty", sb.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
